// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
//   Valid/ready handshake bundle carrying a control word and a data payload.
//   master: producer side (drives valid, ctrl, data; observes ready)
//   slave : consumer side (observes valid, ctrl, data; drives ready)
//   Parameters: CTRL_W control width, DATA_W payload width.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 138
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Pipeline-stage register with valid/ready handshake and a 2-entry skid
//   buffer (main + skid). Control bits are forced to zero in bubbles. No
//   combinational path from out_if.ready to in_if.ready.
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous reset, active-low
//   flush      synchronous kill of held entries and of this cycle's input
//   in_if      upstream handshake (slave): valid/ctrl/data in, ready out
//   out_if     downstream handshake (master): valid/ctrl/data out, ready in
//   occupancy  held entries: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out valid and not ready
//   stall_clr  synchronous clear of stall_cnt
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | nothing held, out valid low
// ONE   | main entry valid, skid empty
// FULL  | main and skid valid, input not accepted
module pipe_stage_skid #(
    parameter int CTRL_W    = 9,
    parameter int DATA_W    = 138,
    parameter bit ZERO_DATA = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    pipe_stage_skid_if.slave  in_if,
    pipe_stage_skid_if.master out_if,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic out_valid;
    logic in_ready;
    logic acc;
    logic rel;

    // in_ready only looks at registered state, flush and reset
    assign in_ready  = reset_n & (state_q != FULL) & ~flush;
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_if.valid & in_ready;
    assign rel       = out_valid & out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_if.data  = main_data_q;
    assign occupancy    = state_q;
    assign stall_cnt    = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (ZERO_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (acc && rel) begin
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                    end else if (rel) begin
                        main_ctrl_d = '0;
                        if (ZERO_DATA) main_data_d = '0;
                        state_d = EMPTY;
                    end else if (acc) begin
                        skid_ctrl_d = in_if.ctrl;
                        skid_data_d = in_if.data;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    // skid moves up behind the released main entry, keeping order
                    if (rel) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        if (ZERO_DATA) skid_data_d = '0;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_if.ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
